// File: rtl/music_sweep_ctrl.sv
// rtl/music_sweep_ctrl.sv - MUSIC pseudo-spectrum sweep engine; optional peak tracking under MUSIC_PEAK_TRACK_EN
module music_sweep_ctrl #(
    parameter int M      = 4,
    parameter int K      = 2,
    parameter int EW     = 32,
    parameter int VW     = 16,
    parameter int SW     = 8,
    parameter int NTHETA = 181,
    parameter int TW     = 8,
    localparam int AW    = $clog2(M),
    localparam int DW    = SW + VW + AW,
    localparam int PW    = 2 * DW + $clog2(K + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 evd_valid,
    output logic                 evd_ready,
    input  logic [M*EW-1:0]      eig_val,
    input  logic [M*M*VW-1:0]    eig_vec,
    output logic [TW+AW-1:0]     steer_addr,
    input  logic [SW-1:0]        steer_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TW-1:0]        out_theta,
    output logic [PW-1:0]        out_power,
`ifdef MUSIC_PEAK_TRACK_EN
    output logic [TW-1:0]        peak_theta,
    output logic [PW-1:0]        peak_power,
`endif
    output logic                 busy,
    output logic                 done
);

    localparam int KW  = (K > 1) ? $clog2(K) : 1;
    localparam int PRW = SW + VW;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_FETCH, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   evd_ready_q, busy_q, out_valid_q, done_q;

    logic signed [EW-1:0] val_q [M];
    logic signed [VW-1:0] vec_q [M][M];
    logic signed [SW-1:0] a_q   [M];
    logic [AW-1:0]        sel_q [K];
    logic [M-1:0]         chosen_q;
    logic signed [EW-1:0] best_val_q;
    logic [AW-1:0]        best_idx_q;
    logic                 found_q;
    logic [AW-1:0]        idx_q;
    logic [KW-1:0]        k_q;
    logic [AW:0]          fcnt_q;
    logic [TW-1:0]        theta_q;
    logic signed [DW-1:0] dot_q;
    logic [PW-1:0]        power_q;
    logic [TW+AW-1:0]     steer_addr_q;
`ifdef MUSIC_PEAK_TRACK_EN
    logic [TW-1:0]        peak_theta_q;
    logic [PW-1:0]        peak_power_q;
`endif

    logic                 last_idx, last_k, last_theta, fetch_end, fetch_more;
    logic                 take;
    logic [AW-1:0]        pick_idx;
    logic signed [EW-1:0] pick_val;
    logic [AW-1:0]        fm1, fp1;
    logic signed [SW-1:0] a_cur;
    logic signed [VW-1:0] v_cur;
    logic [PRW-1:0]       a_x, v_x;
    logic signed [PRW-1:0] prod_w;
    logic signed [DW-1:0] prod_x, dot_sum;
    logic [2*DW-1:0]      sum_x, sq_w;
    logic [PW-1:0]        power_add;

    assign last_idx   = (idx_q == AW'(M - 1));
    assign last_k     = (k_q == KW'(K - 1));
    assign last_theta = (theta_q == TW'(NTHETA - 1));
    assign fetch_end  = (fcnt_q == (AW + 1)'(M));
    assign fetch_more = (fcnt_q < (AW + 1)'(M - 1));
    assign fm1        = fcnt_q[AW-1:0] - AW'(1);
    assign fp1        = fcnt_q[AW-1:0] + AW'(1);

    // Selection scan: keep the running minimum over unchosen indices; strict compare keeps the lowest index on ties
    always_comb begin
        take     = !chosen_q[idx_q] && (!found_q || (val_q[idx_q] < best_val_q));
        pick_idx = take ? idx_q : best_idx_q;
        pick_val = take ? val_q[idx_q] : best_val_q;
    end

    // MAC datapath: operands are sign-extended to the product width so the low bits are the exact signed product
    always_comb begin
        a_cur     = a_q[idx_q];
        v_cur     = vec_q[sel_q[k_q]][idx_q];
        a_x       = {{VW{a_cur[SW-1]}}, a_cur};
        v_x       = {{SW{v_cur[VW-1]}}, v_cur};
        prod_w    = a_x * v_x;
        prod_x    = {{AW{prod_w[PRW-1]}}, prod_w};
        dot_sum   = dot_q + prod_x;
        sum_x     = {{DW{dot_sum[DW-1]}}, dot_sum};
        sq_w      = sum_x * sum_x;
        power_add = power_q + {{(PW - 2 * DW){1'b0}}, sq_w};
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (evd_valid)           state_d = S_SELECT;
            S_SELECT: if (last_idx && last_k)  state_d = S_FETCH;
            S_FETCH:  if (fetch_end)           state_d = S_MAC;
            S_MAC:    if (last_idx && last_k)  state_d = S_OUT;
            S_OUT:    if (out_ready)           state_d = last_theta ? S_DONE : S_FETCH;
            S_DONE:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // State register with status outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            evd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            evd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            out_valid_q <= (state_d == S_OUT);
            done_q      <= (state_d == S_DONE);
        end
    end

    // Datapath: latch eigen data, run subspace selection, fetch steering vector, accumulate projection power
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                val_q[i] <= '0;
                a_q[i]   <= '0;
                for (int j = 0; j < M; j++) vec_q[i][j] <= '0;
            end
            for (int i = 0; i < K; i++) sel_q[i] <= '0;
            chosen_q     <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            found_q      <= 1'b0;
            idx_q        <= '0;
            k_q          <= '0;
            fcnt_q       <= '0;
            theta_q      <= '0;
            dot_q        <= '0;
            power_q      <= '0;
            steer_addr_q <= '0;
`ifdef MUSIC_PEAK_TRACK_EN
            peak_theta_q <= '0;
            peak_power_q <= '1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (evd_valid) begin
                        for (int i = 0; i < M; i++) begin
                            val_q[i] <= eig_val[i*EW +: EW];
                            for (int j = 0; j < M; j++) vec_q[i][j] <= eig_vec[(i*M+j)*VW +: VW];
                        end
                        theta_q  <= '0;
                        idx_q    <= '0;
                        k_q      <= '0;
                        chosen_q <= '0;
                        found_q  <= 1'b0;
`ifdef MUSIC_PEAK_TRACK_EN
                        peak_theta_q <= '0;
                        peak_power_q <= '1;
`endif
                    end
                end
                S_SELECT: begin
                    best_val_q <= pick_val;
                    best_idx_q <= pick_idx;
                    found_q    <= found_q | take;
                    idx_q      <= idx_q + AW'(1);
                    if (last_idx) begin
                        sel_q[k_q]         <= pick_idx;
                        chosen_q[pick_idx] <= 1'b1;
                        found_q            <= 1'b0;
                        idx_q              <= '0;
                        k_q                <= k_q + KW'(1);
                        if (last_k) begin
                            k_q          <= '0;
                            fcnt_q       <= '0;
                            steer_addr_q <= {theta_q, AW'(0)};
                            power_q      <= '0;
                            dot_q        <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    fcnt_q <= fcnt_q + (AW + 1)'(1);
                    if (fcnt_q != '0) a_q[fm1] <= steer_data;
                    if (fetch_more) steer_addr_q <= {theta_q, fp1};
                    if (fetch_end) begin
                        idx_q <= '0;
                        k_q   <= '0;
                    end
                end
                S_MAC: begin
                    dot_q <= dot_sum;
                    idx_q <= idx_q + AW'(1);
                    if (last_idx) begin
                        dot_q   <= '0;
                        power_q <= power_add;
                        idx_q   <= '0;
                        k_q     <= k_q + KW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
`ifdef MUSIC_PEAK_TRACK_EN
                        if (power_q < peak_power_q) begin
                            peak_power_q <= power_q;
                            peak_theta_q <= theta_q;
                        end
`endif
                        if (!last_theta) begin
                            theta_q      <= theta_q + TW'(1);
                            fcnt_q       <= '0;
                            steer_addr_q <= {theta_q + TW'(1), AW'(0)};
                            power_q      <= '0;
                            dot_q        <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign evd_ready  = evd_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign out_theta  = theta_q;
    assign out_power  = power_q;
    assign steer_addr = steer_addr_q;
`ifdef MUSIC_PEAK_TRACK_EN
    assign peak_theta = peak_theta_q;
    assign peak_power = peak_power_q;
`endif

endmodule

// File: tb/tb_music_sweep_ctrl.sv
// tb/tb_music_sweep_ctrl.sv - directed self-checking bench for music_sweep_ctrl
`timescale 1ns/1ps
module tb_music_sweep_ctrl;

    localparam int M = 4, K = 2, EW = 32, VW = 16, SW = 8, NTHETA = 181, TW = 8;
    localparam int AW = 2, DW = SW + VW + AW, PW = 2 * DW + 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               evd_valid = 1'b0;
    logic               evd_ready;
    logic [M*EW-1:0]    eig_val = '0;
    logic [M*M*VW-1:0]  eig_vec = '0;
    logic [TW+AW-1:0]   steer_addr;
    logic [SW-1:0]      steer_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [TW-1:0]      out_theta;
    logic [PW-1:0]      out_power;
    logic               busy;
    logic               done;
`ifdef MUSIC_PEAK_TRACK_EN
    logic [TW-1:0]      peak_theta;
    logic [PW-1:0]      peak_power;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rom_mode = 0;

    always #5 clk = ~clk;

    music_sweep_ctrl #(
        .M(M), .K(K), .EW(EW), .VW(VW), .SW(SW), .NTHETA(NTHETA), .TW(TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evd_valid  (evd_valid),
        .evd_ready  (evd_ready),
        .eig_val    (eig_val),
        .eig_vec    (eig_vec),
        .steer_addr (steer_addr),
        .steer_data (steer_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_theta  (out_theta),
        .out_power  (out_power),
`ifdef MUSIC_PEAK_TRACK_EN
        .peak_theta (peak_theta),
        .peak_power (peak_power),
`endif
        .busy       (busy),
        .done       (done)
    );

    // Steering ROM: 0 all +1, 1 all -128, 2 dips at theta 40/90, 3 theta- and m-dependent
    function automatic logic [SW-1:0] rom_val(input logic [TW+AW-1:0] addr);
        int t, m, v;
        t = int'(addr[TW+AW-1:AW]);
        m = int'(addr[AW-1:0]);
        case (rom_mode)
            1:       v = -128;
            2:       v = (t == 40 || t == 90) ? 1 : 2;
            3:       v = (t % 5) + m - 2;
            default: v = 1;
        endcase
        return SW'(v);
    endfunction

    always @(posedge clk) steer_data <= rom_val(steer_addr);

    // Expected power for identity eigenvectors with noise subspace {e3, e1}: a[3]^2 + a[1]^2
    function automatic logic [63:0] exp_power(input int t);
        int t5;
        t5 = t % 5;
        case (rom_mode)
            2:       return (t == 40 || t == 90) ? 64'd2 : 64'd8;
            3:       return 64'(2 * t5 * t5 + 2);
            default: return 64'd2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // vmode 0: identity vectors, 1: all -32768, 2: vector i has every element i+1
    task automatic set_eig(input int v0, input int v1, input int v2, input int v3, input int vmode);
        int vals[4];
        int e;
        vals = '{v0, v1, v2, v3};
        for (int i = 0; i < M; i++) begin
            eig_val[i*EW +: EW] = EW'(vals[i]);
            for (int m = 0; m < M; m++) begin
                case (vmode)
                    1:       e = -32768;
                    2:       e = i + 1;
                    default: e = (i == m) ? 1 : 0;
                endcase
                eig_vec[(i*M+m)*VW +: VW] = VW'(e);
            end
        end
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        check({tag, "_evd_ready"}, 64'(evd_ready), 64'd1);
        evd_valid = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        evd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait for the first sample and leave it pending (out_ready low)
    task automatic first_sample(input string tag, input logic [63:0] exp, input bit keep_valid);
        bit found = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            evd_valid = keep_valid;
            if (out_valid) found = 1;
        end
        evd_valid = 1'b0;
        check({tag, "_seen"}, 64'(found), 64'd1);
        check({tag, "_theta"}, 64'(out_theta), 64'd0);
        check({tag, "_power"}, 64'(out_power), exp);
    endtask

    task automatic run_sweep(input bit stall, input string tag);
        int cyc = 0, nsamp = 0, bad_theta = 0, bad_pw = 0, bad_hold = 0, busy_cyc = 0, n_done = 0;
        bit held = 0, last_hs = 0, fin = 0, saw_done = 0;
        logic [TW-1:0] h_theta = '0;
        logic [PW-1:0] h_pw = '0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            evd_valid = 1'b0;
            cyc++;
            if (busy) busy_cyc++;
            if (done) n_done++;
            if (held && (!out_valid || out_theta !== h_theta || out_power !== h_pw)) bad_hold++;
            held = 0;
            if (last_hs) begin
                saw_done = done;
                fin = 1;
            end else if (out_valid) begin
                out_ready = stall ? (cyc % 3 == 0) : 1'b1;
                if (out_ready) begin
                    if (int'(out_theta) != nsamp) bad_theta++;
                    if (64'(out_power) != exp_power(int'(out_theta))) bad_pw++;
                    nsamp++;
                    last_hs = (int'(out_theta) == NTHETA - 1);
                end else begin
                    held = 1;
                    h_theta = out_theta;
                    h_pw = out_power;
                end
            end else begin
                out_ready = !stall;
            end
        end
        check({tag, "_nsamp"}, 64'(nsamp), 64'(NTHETA));
        check({tag, "_theta_seq_errs"}, 64'(bad_theta), 64'd0);
        check({tag, "_power_errs"}, 64'(bad_pw), 64'd0);
        check({tag, "_hold_errs"}, 64'(bad_hold), 64'd0);
        check({tag, "_done_after_last"}, 64'(saw_done), 64'd1);
        check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        if (!stall) check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd2543);
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done_clear"}, 64'(done), 64'd0);
        check({tag, "_idle_ready"}, 64'(evd_ready), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit found;
        logic [63:0] ext;
        ext = 64'd2 * (64'd4 * 64'd4194304) * (64'd4 * 64'd4194304);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_evd_ready", 64'(evd_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_theta", 64'(out_theta), 64'd0);
        check("rst_out_power", 64'(out_power), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_steer_addr", 64'(steer_addr), 64'd0);
`ifdef MUSIC_PEAK_TRACK_EN
        check("rst_peak_theta", 64'(peak_theta), 64'd0);
        check("rst_peak_power", 64'(peak_power), {{(64-PW){1'b0}}, {PW{1'b1}}});
`endif

        // Subspace selection {40,10,30,5} -> sel {3,1}; dots 16 and 8
        rom_mode = 0;
        set_eig(40, 10, 30, 5, 2);
        accept("sel");
        first_sample("sel", 64'd320, 1'b0);
        check("sel0", 64'(dut.sel_q[0]), 64'd3);
        check("sel1", 64'(dut.sel_q[1]), 64'd1);
        pulse_reset();

        // Ties pick lowest indices
        set_eig(7, 7, 7, 7, 2);
        accept("tie");
        first_sample("tie", 64'd80, 1'b0);
        check("tie_sel0", 64'(dut.sel_q[0]), 64'd0);
        check("tie_sel1", 64'(dut.sel_q[1]), 64'd1);
        pulse_reset();

        // Signed compare: {-5,3,-20,0} -> sel {2,0}; dots 12 and 4
        set_eig(-5, 3, -20, 0, 2);
        accept("neg");
        first_sample("neg", 64'd160, 1'b0);
        check("neg_sel0", 64'(dut.sel_q[0]), 64'd2);
        check("neg_sel1", 64'(dut.sel_q[1]), 64'd0);
        pulse_reset();

        // Extreme operands; new eigen data offered while busy must be ignored
        rom_mode = 1;
        set_eig(40, 10, 30, 5, 1);
        accept("ext");
        @(negedge clk);
        set_eig(40, 10, 30, 5, 0);
        check("ext_busy_not_ready", 64'(evd_ready), 64'd0);
        first_sample("ext", ext, 1'b1);
        pulse_reset();

        // Reset in the middle of MAC at theta 57
        rom_mode = 0;
        set_eig(40, 10, 30, 5, 0);
        accept("abort");
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            evd_valid = 1'b0;
            out_ready = 1'b1;
            if (out_valid && out_theta == TW'(56)) found = 1;
        end
        check("abort_reach_56", 64'(found), 64'd1);
        repeat (8) @(negedge clk);
        check("abort_in_mac_addr", 64'(steer_addr), 64'(57 * 4 + 3));
        check("abort_in_mac_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_evd_ready", 64'(evd_ready), 64'd1);
        check("abort_power", 64'(out_power), 64'd0);

        // Full sweep after the abort restarts at theta 0, ready tied high
        accept("full");
        run_sweep(1'b0, "full");

        // Backpressure: ready high one cycle in three, theta-dependent powers
        rom_mode = 3;
        accept("stall");
        run_sweep(1'b1, "stall");

`ifdef MUSIC_PEAK_TRACK_EN
        rom_mode = 2;
        accept("peak");
        run_sweep(1'b0, "peak");
        check("peak_theta", 64'(peak_theta), 64'd40);
        check("peak_power", 64'(peak_power), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
